xbar_rr_nxm: RTL and testbench

Parametrised N-input, M-output crossbar for the mesh router datapath. Unlike the single-transfer crossbar, every output port runs its own round-robin arbiter and registered output stage, so up to min(IN_N, OUT_N) flits move per cycle. Each flit carries its destination port index, and both sides use valid/ready handshakes. It sits between the input buffers and the output links of a router.

---
 rtl/xbar_rr_nxm_pkg.sv | 23 ++
 rtl/xbar_rr_nxm_arbiter.sv | 74 +++++++
 rtl/xbar_rr_nxm.sv | 147 ++++++++++++++
 tb/tb_xbar_rr_nxm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_rr_nxm_pkg.sv
// ---------------------------------------------------------------------------
// xbar_rr_nxm_pkg
// Shared router package: mesh port-index constants, the default flit width
// and a small round-robin helper used by the crossbar arbiters.
// ---------------------------------------------------------------------------
package xbar_rr_nxm_pkg;

    // Mesh router port indices, shared by every router block
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Default flit width for the router datapath
    localparam int FLIT_WIDTH = 8;

    // Index following idx in a ring of n entries
    function automatic int rrNext(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbar_rr_nxm_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. The search for a
// requester starts at the pointer and wraps modulo N; the pointer moves to
// one past the winner, and only when the arbiter is enabled and somebody
// requested.
//
// Ports:
//   clk_i   in   1       clock, rising edge
//   rst_i   in   1       synchronous active-high reset (pointer -> 0)
//   en_i    in   1       arbitration enable; no grant when low
//   req_i   in   N       request vector
//   gnt_o   out  N       one-hot grant (combinational)
//   idx_o   out  IDX_W   binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
    import xbar_rr_nxm_pkg::*;
#(
    parameter  int N     = 5,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    // Walk the requesters starting at the pointer, wrapping around the ring,
    // and grant the first one found. Nothing is granted while disabled so a
    // full output never steals a flit from its input.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

    // The pointer advances past the winner only on an actual grant, so an
    // idle or blocked output keeps its place in the rotation.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && |req_i) begin
            ptr_d = IDX_W'(rrNext(int'(idx_o), N));
        end
    end

    // Pointer register with synchronous reset back to requester 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xbar_rr_nxm.sv
// ---------------------------------------------------------------------------
// xbar_rr_nxm
// N-input, M-output crossbar for the mesh router datapath. Each output has
// its own round-robin arbiter and registered output stage, so several flits
// can cross per cycle. Flits carry their destination index; flits with an
// out-of-range destination are accepted, discarded and flagged on err_o.
//
// Ports:
//   clk_i       in   1                  clock, rising edge
//   rst_i       in   1                  synchronous active-high reset
//   in_data_i   in   IN_N*DATA_WIDTH    input flits, port i at slice i
//   in_dst_i    in   IN_N*DST_W         destination output index per input
//   in_vld_i    in   IN_N               input flit valid
//   in_rdy_o    out  IN_N               input flit accepted (combinational)
//   out_data_o  out  OUT_N*DATA_WIDTH   registered output flits
//   out_src_o   out  OUT_N*SRC_W        registered source input index
//   out_vld_o   out  OUT_N              output flit valid
//   out_rdy_i   in   OUT_N              downstream accepts output flit
//   err_o       out  1                  pulse: flit dropped, illegal dest
// ---------------------------------------------------------------------------
module xbar_rr_nxm
    import xbar_rr_nxm_pkg::*;
#(
    parameter  int DATA_WIDTH = FLIT_WIDTH,
    parameter  int IN_N       = 5,
    parameter  int OUT_N      = 5,
    localparam int DST_W      = $clog2(OUT_N),
    localparam int SRC_W      = $clog2(IN_N)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [IN_N*DATA_WIDTH-1:0]  in_data_i,
    input  logic [IN_N*DST_W-1:0]       in_dst_i,
    input  logic [IN_N-1:0]             in_vld_i,
    output logic [IN_N-1:0]             in_rdy_o,
    output logic [OUT_N*DATA_WIDTH-1:0] out_data_o,
    output logic [OUT_N*SRC_W-1:0]      out_src_o,
    output logic [OUT_N-1:0]            out_vld_o,
    input  logic [OUT_N-1:0]            out_rdy_i,
    output logic                        err_o
);

    logic [IN_N-1:0]       reqMat [OUT_N];
    logic [IN_N-1:0]       gntMat [OUT_N];
    logic [SRC_W-1:0]      gntIdx [OUT_N];
    logic [OUT_N-1:0]      canLoad;
    logic [IN_N-1:0]       columnReq;
    logic [IN_N-1:0]       columnGnt;
    logic [IN_N-1:0]       illegal;

    logic [DATA_WIDTH-1:0] outData_q [OUT_N];
    logic [DATA_WIDTH-1:0] outData_d [OUT_N];
    logic [SRC_W-1:0]      outSrc_q  [OUT_N];
    logic [SRC_W-1:0]      outSrc_d  [OUT_N];
    logic [OUT_N-1:0]      outVld_q;
    logic [OUT_N-1:0]      outVld_d;
    logic                  err_q;
    logic                  err_d;

    // Request matrix: row j collects every valid input addressed to output j.
    // An output can take a new flit when it is empty or being drained now.
    always_comb begin
        for (int j = 0; j < OUT_N; j++) begin
            reqMat[j] = '0;
            for (int i = 0; i < IN_N; i++) begin
                reqMat[j][i] = in_vld_i[i] &&
                               (in_dst_i[i*DST_W +: DST_W] == DST_W'(j));
            end
            canLoad[j] = !outVld_q[j] || out_rdy_i[j];
        end
    end

    // One arbiter per output; enabling it with canLoad keeps a blocked output
    // from granting and from moving its pointer.
    for (genvar j = 0; j < OUT_N; j++) begin : genArb
        rr_arbiter #(
            .N(IN_N)
        ) uArb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (canLoad[j]),
            .req_i (reqMat[j]),
            .gnt_o (gntMat[j]),
            .idx_o (gntIdx[j])
        );
    end

    // Input side: a valid input that matches no output row has an illegal
    // destination and is swallowed immediately. Since each input addresses a
    // single output, OR-ing the grant columns gives its ready directly.
    always_comb begin
        columnReq = '0;
        columnGnt = '0;
        for (int j = 0; j < OUT_N; j++) begin
            columnReq = columnReq | reqMat[j];
            columnGnt = columnGnt | gntMat[j];
        end
        illegal  = in_vld_i & ~columnReq;
        in_rdy_o = (rst_i) ? '0 : (illegal | columnGnt);
    end

    // Output stage next state: a grant loads the winner's flit and source;
    // otherwise a drained flit clears valid while data and source hold.
    always_comb begin
        err_d = |illegal;
        for (int j = 0; j < OUT_N; j++) begin
            outData_d[j] = outData_q[j];
            outSrc_d[j]  = outSrc_q[j];
            outVld_d[j]  = outVld_q[j] && !out_rdy_i[j];
            if (|gntMat[j]) begin
                outData_d[j] = in_data_i[int'(gntIdx[j])*DATA_WIDTH +: DATA_WIDTH];
                outSrc_d[j]  = gntIdx[j];
                outVld_d[j]  = 1'b1;
            end
        end
    end

    // Output registers and error flag, all cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < OUT_N; j++) begin
                outData_q[j] <= '0;
                outSrc_q[j]  <= '0;
            end
            outVld_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int j = 0; j < OUT_N; j++) begin
                outData_q[j] <= outData_d[j];
                outSrc_q[j]  <= outSrc_d[j];
            end
            outVld_q <= outVld_d;
            err_q    <= err_d;
        end
    end

    // Flatten the per-output registers onto the packed ports
    always_comb begin
        for (int j = 0; j < OUT_N; j++) begin
            out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = outData_q[j];
            out_src_o[j*SRC_W +: SRC_W]            = outSrc_q[j];
        end
        out_vld_o = outVld_q;
        err_o     = err_q;
    end

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// ---------------------------------------------------------------------------
// tb_xbar_rr_nxm
// Directed testbench for xbar_rr_nxm with IN_N = OUT_N = 5, 8-bit flits.
// Inputs change on the falling edge; in_rdy is sampled just after that and
// registered outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_xbar_rr_nxm;

    localparam int DW    = 8;
    localparam int NIN   = 5;
    localparam int NOUT  = 5;
    localparam int DSTW  = 3;
    localparam int SRCW  = 3;

    logic                 clk;
    logic                 rst;
    logic [NIN*DW-1:0]    inData;
    logic [NIN*DSTW-1:0]  inDst;
    logic [NIN-1:0]       inVld;
    logic [NIN-1:0]       inRdy;
    logic [NOUT*DW-1:0]   outData;
    logic [NOUT*SRCW-1:0] outSrc;
    logic [NOUT-1:0]      outVld;
    logic [NOUT-1:0]      outRdy;
    logic                 err;

    int vecCount;
    int missCount;
    int order [6];

    xbar_rr_nxm #(
        .DATA_WIDTH(DW),
        .IN_N(NIN),
        .OUT_N(NOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (inData),
        .in_dst_i   (inDst),
        .in_vld_i   (inVld),
        .in_rdy_o   (inRdy),
        .out_data_o (outData),
        .out_src_o  (outSrc),
        .out_vld_o  (outVld),
        .out_rdy_i  (outRdy),
        .err_o      (err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] getData(input int j);
        return outData[j*DW +: DW];
    endfunction

    function automatic logic [SRCW-1:0] getSrc(input int j);
        return outSrc[j*SRCW +: SRCW];
    endfunction

    // Single comparison point: counts every vector and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h",
                     tag, observed, expected);
        end
    endtask

    // Drive one input port with a valid flit
    task automatic applyStimulus(input int port, input int dst, input logic [DW-1:0] data);
        logic [31:0] dstBits;
        dstBits = dst;
        inVld[port]                = 1'b1;
        inDst[port*DSTW +: DSTW]   = dstBits[DSTW-1:0];
        inData[port*DW +: DW]      = data;
    endtask

    task automatic clearInputs();
        inVld  = '0;
        inDst  = '0;
        inData = '0;
    endtask

    // Move to the next falling edge through one rising edge
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        order     = '{0, 2, 4, 0, 2, 4};

        // Reset, with an input offered that must not be accepted
        rst    = 1'b1;
        outRdy = '1;
        clearInputs();
        applyStimulus(0, 3, 8'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset in_rdy", inRdy, 5'b00000);
        checkOutput("reset out_vld", outVld, 5'b00000);
        checkOutput("reset err", err, 1'b0);
        checkOutput("reset out_data", outData, 40'h0);
        checkOutput("reset out_src", outSrc, 15'h0);

        // Single transfer: in0 -> out3
        rst = 1'b0;
        clearInputs();
        applyStimulus(0, 3, 8'hA5);
        #1;
        checkOutput("single in_rdy", inRdy, 5'b00001);
        stepCycle();
        clearInputs();
        checkOutput("single out_vld", outVld, 5'b01000);
        checkOutput("single data3", getData(3), 8'hA5);
        checkOutput("single src3", getSrc(3), 0);

        // Parallel transfers in one cycle; out3 drains at the same edge
        applyStimulus(0, 1, 8'h11);
        applyStimulus(1, 2, 8'h22);
        applyStimulus(2, 0, 8'h33);
        #1;
        checkOutput("parallel in_rdy", inRdy, 5'b00111);
        stepCycle();
        clearInputs();
        checkOutput("parallel out_vld", outVld, 5'b00111);
        checkOutput("parallel data1", getData(1), 8'h11);
        checkOutput("parallel data2", getData(2), 8'h22);
        checkOutput("parallel data0", getData(0), 8'h33);
        checkOutput("parallel src1", getSrc(1), 0);
        checkOutput("parallel src2", getSrc(2), 1);
        checkOutput("parallel src0", getSrc(0), 2);

        // Contention on out4 by inputs 0, 2, 4 for six cycles
        applyStimulus(0, 4, 8'h40);
        applyStimulus(2, 4, 8'h42);
        applyStimulus(4, 4, 8'h44);
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput($sformatf("contend rdy k=%0d", k), inRdy, 1 << order[k]);
            if (k > 0) begin
                checkOutput($sformatf("contend src k=%0d", k - 1), getSrc(4), order[k-1]);
                checkOutput($sformatf("contend data k=%0d", k - 1), getData(4), 8'h40 + order[k-1]);
            end
            stepCycle();
        end
        clearInputs();
        checkOutput("contend src k=5", getSrc(4), order[5]);
        checkOutput("contend vld4", outVld[4], 1'b1);
        stepCycle();
        checkOutput("drain all", outVld, 5'b00000);

        // Backpressure on out1: fill it while downstream is stalled
        outRdy[1] = 1'b0;
        applyStimulus(0, 1, 8'h77);
        #1;
        checkOutput("bp fill rdy", inRdy, 5'b00001);
        stepCycle();
        clearInputs();
        checkOutput("bp fill vld1", outVld[1], 1'b1);
        checkOutput("bp fill data1", getData(1), 8'h77);
        applyStimulus(3, 1, 8'h99);
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput($sformatf("bp blocked rdy k=%0d", k), inRdy, 5'b00000);
            stepCycle();
            checkOutput($sformatf("bp hold data1 k=%0d", k), getData(1), 8'h77);
            checkOutput($sformatf("bp hold src1 k=%0d", k), getSrc(1), 0);
            checkOutput($sformatf("bp hold vld1 k=%0d", k), outVld[1], 1'b1);
        end
        outRdy[1] = 1'b1;
        #1;
        checkOutput("bp release rdy", inRdy, 5'b01000);
        stepCycle();
        clearInputs();
        checkOutput("bp reload data1", getData(1), 8'h99);
        checkOutput("bp reload src1", getSrc(1), 3);
        checkOutput("bp reload vld1", outVld[1], 1'b1);
        stepCycle();
        checkOutput("bp drained vld1", outVld[1], 1'b0);

        // Illegal destination 6 on in2
        applyStimulus(2, 6, 8'hEE);
        #1;
        checkOutput("illegal rdy", inRdy, 5'b00100);
        stepCycle();
        clearInputs();
        checkOutput("illegal err", err, 1'b1);
        checkOutput("illegal out_vld", outVld, 5'b00000);
        stepCycle();
        checkOutput("illegal err clears", err, 1'b0);
        checkOutput("illegal out_vld later", outVld, 5'b00000);

        // Reset mid-operation: load outs 1, 2, 4 under stall; out4 pointer -> 4
        outRdy = '0;
        applyStimulus(0, 1, 8'h51);
        applyStimulus(1, 2, 8'h52);
        applyStimulus(3, 4, 8'h54);
        stepCycle();
        clearInputs();
        checkOutput("pre-reset out_vld", outVld, 5'b10110);
        rst = 1'b1;
        stepCycle();
        rst    = 1'b0;
        outRdy = '1;
        checkOutput("post-reset out_vld", outVld, 5'b00000);
        checkOutput("post-reset err", err, 1'b0);
        checkOutput("post-reset out_data", outData, 40'h0);
        checkOutput("post-reset out_src", outSrc, 15'h0);
        applyStimulus(0, 4, 8'h60);
        applyStimulus(2, 4, 8'h62);
        applyStimulus(4, 4, 8'h64);
        #1;
        checkOutput("post-reset grant rdy", inRdy, 5'b00001);
        stepCycle();
        clearInputs();
        checkOutput("post-reset src4", getSrc(4), 0);
        checkOutput("post-reset data4", getData(4), 8'h60);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
